alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit execute-stage ALU. It accepts one operation per valid/ready transfer, registers the result and a full Z/N/C/V flag set, and holds the output until downstream accepts it. It adds an iterative signed multiply and a flags-only compare, and sits between decode/register-read and writeback in the EXE stage.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
MUL_EN, 1, 1 = opcode 4'h8 performs multiply; 0 = opcode 4'h8 is treated as undefined

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
mode  in  4  opcode
s1  in  WIDTH  first operand (signed)
s2  in  WIDTH  second operand (signed)
imm  in  WIDTH  immediate
ex_in  in  WIDTH  external input port value
flags_clr  in  1  synchronous clear of the flag register
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
result  out  WIDTH  registered result (signed)
flags  out  4  {Z,N,C,V}, registered
busy  out  1  multiply in progress

Behaviour:
- Reset (async): state IDLE, result=0, flags=0, out_valid=0, busy=0, multiply registers cleared. Reset mid-multiply aborts the operation and no result is produced.
- A transfer occurs when in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready). It is combinational from state and out_ready.
- out_valid is held with result and flags stable until out_ready. An out_ready in a cycle with out_valid=0 has no effect.
- Output transfer and new input transfer may occur in the same cycle. The new result replaces the old one, and out_valid stays 1.
- Latency: all single-cycle ops set out_valid at the rising edge of the accept cycle, so the result is visible the next cycle.
- Opcodes:
  - 4'h1 ADD: s1+s2. C = unsigned carry-out. V = signed overflow.
  - 4'h2 SUB: s1-s2. C = 1 when no borrow (s1>=s2 unsigned). V = signed overflow.
  - 4'h3 NAND: ~(s1&s2). C and V unchanged.
  - 4'h4 SHL: {s1[W-2:0],0}. C = s1[W-1]. V unchanged.
  - 4'h5 SHR (logical): {0,s1[W-1:1]}. C = s1[0]. V unchanged.
  - 4'h6 OUT and 4'hE STORE: result = s1. Flags unchanged.
  - 4'h7 IN: result = ex_in. Flags unchanged.
  - 4'hF LOADIMM: result = imm. Flags unchanged.
  - 4'h9 CMP: flags as for SUB. result = s1.
  - 4'h8 MUL: signed multiply (see below).
  - Undefined opcodes (0, A-D, and 8 when MUL_EN=0): result = 0, flags unchanged, out_valid still asserted.
- Z = (result==0) and N = result[W-1], for ADD, SUB, NAND, SHL, SHR, CMP and MUL. For CMP they are computed from the difference, not from the result.
- MUL:
  - Accept -> state MUL, busy=1, in_ready=0.
  - One shift-add step per cycle for WIDTH cycles, operating on magnitudes with the sign applied at the end.
  - out_valid and busy=0 are set at the WIDTH-th rising edge after the accept edge, and the state returns to IDLE.
  - result = product[W-1:0].
  - V = 1 if the 2W-bit signed product does not fit in W bits.
  - C = 0. Z and N are taken from result.
  - The previous output stays valid until consumed. If the multiply completes while the old output is still unconsumed, the state stalls in DONE until out_ready, then loads the result.
- flags_clr zeroes all four flags at the edge. If it coincides with a flag-writing op, the op's flags win.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
1. ADD s1=8'd100, s2=8'd50 -> result 8'h96, flags Z0 N1 C0 V1, out_valid 1 cycle after accept.
2. SUB 5-5 -> result 0, Z1 N0 C1 V0. Then CMP 3 vs 7 -> result 3, Z0 N1 C0 V0.
3. MUL -3 x 7 -> result 8'hEB (-21), V0. out_valid exactly 8 cycles after accept; in_ready=0 and busy=1 throughout. Then MUL 16 x 16 -> result 0, Z1 V1.
4. Backpressure: hold out_ready=0 for 3 cycles after a LOADIMM 8'h5A. Required: result stays 8'h5A, in_ready=0; the next op is accepted in the same cycle out_ready rises.
5. SHL 8'h81 -> 8'h02, C1. SHR 8'h01 -> 8'h00, C1 Z1. Undefined opcode 4'hB -> result 0, flags unchanged.
6. Assert rst_n low on the 4th cycle of a MUL -> all outputs 0 immediately. After release: in_ready=1 and no stale out_valid.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the EXE-stage ALU and its neighbours.
interface alu_seq_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       mode;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] ex_in;
   logic             flags_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic             busy;

   modport master (
      output in_valid, mode, s1, s2, imm, ex_in, flags_clr, out_ready,
      input  in_ready, out_valid, result, flags, busy
   );

   modport slave (
      input  in_valid, mode, s1, s2, imm, ex_in, flags_clr, out_ready,
      output in_ready, out_valid, result, flags, busy
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops, flags-only compare and an
// iterative signed multiply. Result and {Z,N,C,V} are held until consumed.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_NAND = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_OUT  = 4'h6;
   localparam logic [3:0] OP_IN   = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_STO  = 4'hE;
   localparam logic [3:0] OP_LDI  = 4'hF;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               neg_q, neg_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               out_free;
   logic               accept;

   // Output slot is free when empty or being drained this cycle.
   assign out_free      = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = (state_q == ST_IDLE) && out_free;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.busy      = busy_q;

   // Z/N from the low half, C always 0, V when the signed product overflows WIDTH bits.
   function automatic logic [3:0] mul_flags(input logic [2*WIDTH-1:0] p);
      logic [WIDTH:0] top;
      top       = p[2*WIDTH-1:WIDTH-1];
      mul_flags = {p[WIDTH-1:0] == '0, p[WIDTH-1], 1'b0, ~(&top | ~|top)};
   endfunction

   logic [WIDTH:0]     sum_w, diff_w;
   logic [WIDTH-1:0]   op_res, zn_src, mag1, mag2;
   logic               op_c, op_v, wr_zn, wr_c, wr_v, is_mul;
   logic [2*WIDTH-1:0] acc_step, prod_signed;
   logic               mul_last;

   // Single-cycle opcode decode and one shift-add multiply step.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      sum_w  = {1'b0, bus.s1} + {1'b0, bus.s2};
      diff_w = {1'b0, bus.s1} - {1'b0, bus.s2};
      op_res = '0;
      zn_src = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      wr_zn  = 1'b0;
      wr_c   = 1'b0;
      wr_v   = 1'b0;
      is_mul = 1'b0;
      case (bus.mode)
         OP_ADD: begin
            op_res = sum_w[WIDTH-1:0];
            op_c   = sum_w[WIDTH];
            op_v   = (bus.s1[WIDTH-1] == bus.s2[WIDTH-1]) && (op_res[WIDTH-1] != bus.s1[WIDTH-1]);
            {wr_zn, wr_c, wr_v} = 3'b111;
         end
         OP_SUB, OP_CMP: begin
            op_res = (bus.mode == OP_CMP) ? bus.s1 : diff_w[WIDTH-1:0];
            op_c   = ~diff_w[WIDTH];
            op_v   = (bus.s1[WIDTH-1] != bus.s2[WIDTH-1]) && (diff_w[WIDTH-1] != bus.s1[WIDTH-1]);
            {wr_zn, wr_c, wr_v} = 3'b111;
         end
         OP_NAND: begin
            op_res = ~(bus.s1 & bus.s2);
            wr_zn  = 1'b1;
         end
         OP_SHL: begin
            op_res = {bus.s1[WIDTH-2:0], 1'b0};
            op_c   = bus.s1[WIDTH-1];
            {wr_zn, wr_c} = 2'b11;
         end
         OP_SHR: begin
            op_res = {1'b0, bus.s1[WIDTH-1:1]};
            op_c   = bus.s1[0];
            {wr_zn, wr_c} = 2'b11;
         end
         OP_OUT, OP_STO: op_res = bus.s1;
         OP_IN:          op_res = bus.ex_in;
         OP_LDI:         op_res = bus.imm;
         OP_MUL:         is_mul = MUL_EN;
         default:        op_res = '0;
      endcase
      // Compare reports Z/N of the difference even though it returns s1.
      zn_src = (bus.mode == OP_CMP) ? diff_w[WIDTH-1:0] : op_res;

      mag1        = bus.s1[WIDTH-1] ? (~bus.s1 + 1'b1) : bus.s1;
      mag2        = bus.s2[WIDTH-1] ? (~bus.s2 + 1'b1) : bus.s2;
      acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod_signed = neg_q ? (~acc_step + 1'b1) : acc_step;
      mul_last    = (cnt_q == CW'(WIDTH - 1));
   end

   // Next-state: handshake, result/flag register and multiply sequencing.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      flags_d     = bus.flags_clr ? 4'b0000 : flags_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      busy_d      = busy_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      neg_d       = neg_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mul) begin
               state_d  = ST_MUL;
               busy_d   = 1'b1;
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, mag1};
               mplier_d = mag2;
               neg_d    = bus.s1[WIDTH-1] ^ bus.s2[WIDTH-1];
               cnt_d    = '0;
            end else if (accept) begin
               result_d    = op_res;
               out_valid_d = 1'b1;
               if (wr_zn) flags_d[3:2] = {zn_src == '0, zn_src[WIDTH-1]};
               if (wr_c)  flags_d[1]   = op_c;
               if (wr_v)  flags_d[0]   = op_v;
            end
         end
         ST_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (mul_last) begin
               busy_d = 1'b0;
               if (out_free) begin
                  result_d    = prod_signed[WIDTH-1:0];
                  flags_d     = mul_flags(prod_signed);
                  out_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  acc_d   = prod_signed;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_free) begin
               result_d    = acc_q[WIDTH-1:0];
               flags_d     = mul_flags(acc_q);
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset aborts any multiply in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state_q     <= state_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         neg_q       <= neg_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the handshaked ALU.
module tb_alu_seq;
   localparam int W    = 8;
   localparam int HALF = 1 << (W - 1);
   localparam int FULL = 1 << W;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();
   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Reference model state.
   bit       m_valid;
   int       m_res;
   bit [3:0] m_flags;
   int       m_mul_left;
   bit       m_mul_wait;
   int       m_mul_prod;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap(input int x);
      return x & (FULL - 1);
   endfunction

   function automatic int sx(input int u);
      return (u >= HALF) ? u - FULL : u;
   endfunction

   function automatic bit fits(input int x);
      return (x >= -HALF) && (x < HALF);
   endfunction

   function automatic bit m_ready();
      return (m_mul_left == 0) && !m_mul_wait && (!m_valid || bus.out_ready);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_res = 0; m_flags = 4'b0; m_mul_left = 0; m_mul_wait = 0; m_mul_prod = 0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_edge();
      bit       free, nv, fin;
      int       nr, a, b, sa, sb, d;
      bit [3:0] nf;
      free = !m_valid || bus.out_ready;
      nf   = bus.flags_clr ? 4'b0 : m_flags;
      nv   = m_valid && !bus.out_ready;
      nr   = m_res;
      if (m_mul_left > 0 || m_mul_wait) begin
         fin = m_mul_wait || (m_mul_left == 1);
         if (m_mul_left > 0) m_mul_left--;
         if (fin) begin
            if (free) begin
               nr = wrap(m_mul_prod);
               nv = 1;
               nf = {nr == 0, nr >= HALF, 1'b0, !fits(m_mul_prod)};
               m_mul_wait = 0;
            end else begin
               m_mul_wait = 1;
            end
         end
      end else if (bus.in_valid && m_ready()) begin
         a = int'(bus.s1); b = int'(bus.s2); sa = sx(a); sb = sx(b);
         nv = 1;
         case (bus.mode)
            4'h1: begin nr = wrap(a + b); nf = {nr == 0, nr >= HALF, a + b >= FULL, !fits(sa + sb)}; end
            4'h2: begin nr = wrap(a - b); nf = {nr == 0, nr >= HALF, a >= b, !fits(sa - sb)}; end
            4'h9: begin d = wrap(a - b); nr = a; nf = {d == 0, d >= HALF, a >= b, !fits(sa - sb)}; end
            4'h3: begin nr = wrap(~(a & b)); nf = {nr == 0, nr >= HALF, nf[1], nf[0]}; end
            4'h4: begin nr = wrap(a * 2); nf = {nr == 0, nr >= HALF, a >= HALF, nf[0]}; end
            4'h5: begin nr = a / 2; nf = {nr == 0, nr >= HALF, (a % 2) == 1, nf[0]}; end
            4'h6, 4'hE: nr = a;
            4'h7: nr = int'(bus.ex_in);
            4'hF: nr = int'(bus.imm);
            4'h8: begin m_mul_left = W; m_mul_prod = sa * sb; nv = m_valid && !bus.out_ready; end
            default: nr = 0;
         endcase
      end
      m_valid = nv; m_res = nr; m_flags = nf;
   endtask

   task automatic drive(input bit iv, input logic [3:0] md, input int a, input int b,
                        input int im, input int ex, input bit clr, input bit ordy);
      bus.in_valid  = iv;
      bus.mode      = md;
      bus.s1        = W'(a);
      bus.s2        = W'(b);
      bus.imm       = W'(im);
      bus.ex_in     = W'(ex);
      bus.flags_clr = clr;
      bus.out_ready = ordy;
   endtask

   // One clock: check in_ready before the edge, step model, check outputs after.
   task automatic cycle();
      #1;
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready()});
      model_edge();
      @(posedge clk);
      #1;
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
      check("result", {24'b0, bus.result}, m_res);
      check("flags", {28'b0, bus.flags}, {28'b0, m_flags});
      check("busy", {31'b0, bus.busy}, {31'b0, m_mul_left > 0});
   endtask

   function automatic int rand_opnd();
      int pick;
      if ($urandom_range(3) == 0) begin
         pick = $urandom_range(3);
         case (pick)
            0: return 0;
            1: return HALF;
            2: return HALF - 1;
            default: return FULL - 1;
         endcase
      end
      return $urandom_range(FULL - 1);
   endfunction

   initial begin
      rst_n = 1'b0;
      drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_result", {24'b0, bus.result}, 32'd0);
      check("rst_flags", {28'b0, bus.flags}, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

      // ADD with signed overflow.
      drive(1, 4'h1, 100, 50, 0, 0, 0, 1); cycle();
      check("add_res", {24'b0, bus.result}, 32'h96);
      check("add_flags", {28'b0, bus.flags}, 32'b0101);
      // SUB to zero, then CMP.
      drive(1, 4'h2, 5, 5, 0, 0, 0, 1); cycle();
      check("sub_res", {24'b0, bus.result}, 32'h00);
      check("sub_flags", {28'b0, bus.flags}, 32'b1010);
      drive(1, 4'h9, 3, 7, 0, 0, 0, 1); cycle();
      check("cmp_res", {24'b0, bus.result}, 32'h03);
      check("cmp_flags", {28'b0, bus.flags}, 32'b0100);

      // MUL -3 x 7 with a pending request that must be refused throughout.
      drive(1, 4'h8, 8'hFD, 7, 0, 0, 0, 1); cycle();
      drive(1, 4'h1, 1, 1, 0, 0, 0, 1);
      for (int k = 1; k <= W; k++) begin
         #1 check("mul_in_ready", {31'b0, bus.in_ready}, 32'd0);
         cycle();
         check("mul_out_valid", {31'b0, bus.out_valid}, {31'b0, k == W});
         check("mul_busy", {31'b0, bus.busy}, {31'b0, k < W});
      end
      check("mul_res", {24'b0, bus.result}, 32'hEB);
      check("mul_flags", {28'b0, bus.flags}, 32'b0100);
      drive(1, 4'h8, 16, 16, 0, 0, 0, 1); cycle();
      drive(0, 4'h0, 0, 0, 0, 0, 0, 1);
      for (int k = 1; k <= W; k++) cycle();
      check("mul16_res", {24'b0, bus.result}, 32'h00);
      check("mul16_flags", {28'b0, bus.flags}, 32'b1001);

      // Backpressure after LOADIMM.
      drive(1, 4'hF, 0, 0, 8'h5A, 0, 0, 1); cycle();
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'h1, 1, 2, 0, 0, 0, 0);
         #1 check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
         cycle();
         check("bp_res", {24'b0, bus.result}, 32'h5A);
      end
      drive(1, 4'h1, 1, 2, 0, 0, 0, 1);
      #1 check("bp_release_rdy", {31'b0, bus.in_ready}, 32'd1);
      cycle();
      check("bp_new_res", {24'b0, bus.result}, 32'h03);

      // Shifts and an undefined opcode.
      drive(1, 4'h4, 8'h81, 0, 0, 0, 0, 1); cycle();
      check("shl_res", {24'b0, bus.result}, 32'h02);
      check("shl_flags", {28'b0, bus.flags}, 32'b0010);
      drive(1, 4'h5, 8'h01, 0, 0, 0, 0, 1); cycle();
      check("shr_res", {24'b0, bus.result}, 32'h00);
      check("shr_flags", {28'b0, bus.flags}, 32'b1010);
      drive(1, 4'hB, 8'h33, 8'h44, 0, 0, 0, 1); cycle();
      check("undef_res", {24'b0, bus.result}, 32'h00);
      check("undef_flags", {28'b0, bus.flags}, 32'b1010);
      check("undef_valid", {31'b0, bus.out_valid}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(9) < 7, 4'($urandom_range(15)), rand_opnd(), rand_opnd(),
               rand_opnd(), rand_opnd(), $urandom_range(9) == 0, $urandom_range(9) < 6);
         cycle();
      end

      // Reset during the fourth cycle of a multiply.
      drive(0, 4'h0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 12; k++) cycle();
      drive(1, 4'h8, 5, 9, 0, 0, 0, 1); cycle();
      drive(0, 4'h0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cycle();
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("arst_result", {24'b0, bus.result}, 32'd0);
      check("arst_flags", {28'b0, bus.flags}, 32'd0);
      check("arst_busy", {31'b0, bus.busy}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      for (int k = 0; k < 12; k++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
